mfp_irq_ctrl: RTL and testbench

- Interrupt controller stage of the MFP68901 core, downstream of the timers.
- Collects 16 single-cycle interrupt event pulses: timer T_O_PULSE outputs, GPIP edge detects and USART events.
- Holds them in 68901-style enable/pending/mask/in-service registers and drives a prioritized IRQ to the CPU.
- Answers the CPU interrupt-acknowledge cycle with an 8-bit vector.

---
 rtl/mfp_irq_ctrl_if.sv | 28 ++
 rtl/mfp_irq_ctrl.sv | 140 ++++++++++++++
 tb/tb_mfp_irq_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mfp_irq_ctrl_if.sv
// Bus bundle between the CPU-side logic and the MFP interrupt controller.
//   SRC_PULSE : 16 single-cycle event pulses (bit 15 highest priority)
//   ADDR/WE/DAT_I/DAT_O : register access port (DAT_O combinational)
//   IACK      : interrupt acknowledge pulse from the CPU
//   IRQ       : registered interrupt request
//   VEC_O/VEC_VALID : registered acknowledge vector and its one-cycle strobe
// master = CPU / event side, slave = interrupt controller.
interface mfp_irq_ctrl_if;
  logic [15:0] SRC_PULSE;
  logic [3:0]  ADDR;
  logic        WE;
  logic [7:0]  DAT_I;
  logic [7:0]  DAT_O;
  logic        IACK;
  logic        IRQ;
  logic [7:0]  VEC_O;
  logic        VEC_VALID;

  modport master (
    output SRC_PULSE, ADDR, WE, DAT_I, IACK,
    input  DAT_O, IRQ, VEC_O, VEC_VALID
  );

  modport slave (
    input  SRC_PULSE, ADDR, WE, DAT_I, IACK,
    output DAT_O, IRQ, VEC_O, VEC_VALID
  );
endinterface

// File: rtl/mfp_irq_ctrl.sv
// MFP68901-style interrupt controller.
// Collects 16 event pulses into enable/pending/mask/in-service registers,
// raises a prioritized IRQ and answers IACK with an 8-bit vector.
// Ports:
//   CLK  : system clock, all state on posedge
//   RST  : synchronous active-high reset, clears every register and output
//   bus  : mfp_irq_ctrl_if.slave (events, register port, IACK, IRQ, vector)
// Register map (ADDR): 0 IERA, 1 IERB, 2 IPRA, 3 IPRB, 4 ISRA, 5 ISRB,
//   6 IMRA, 7 IMRB, 8 VR, others read 0.
module mfp_irq_ctrl #(
  parameter logic [7:0] SPURIOUS_VEC = 8'h18
) (
  input logic          CLK,
  input logic          RST,
  mfp_irq_ctrl_if.slave bus
);

  logic [15:0] ier, ipr, isr, imr;
  logic [7:0]  vr;
  logic [15:0] ier_n, ipr_n, isr_n, imr_n;
  logic [7:0]  vr_n;

  logic [15:0] eligible;
  logic [15:0] at_or_above;
  logic [15:0] win_onehot;
  logic [3:0]  win;
  logic        win_vld;
  logic        qualify;
  logic        ack;

  logic        irq_p1;
  logic [7:0]  vec_p1;
  logic        vld_p1;

  logic wr_iera, wr_ierb, wr_ipra, wr_iprb, wr_isra, wr_isrb;
  logic wr_imra, wr_imrb, wr_vr;

  assign wr_iera = bus.WE && (bus.ADDR == 4'd0);
  assign wr_ierb = bus.WE && (bus.ADDR == 4'd1);
  assign wr_ipra = bus.WE && (bus.ADDR == 4'd2);
  assign wr_iprb = bus.WE && (bus.ADDR == 4'd3);
  assign wr_isra = bus.WE && (bus.ADDR == 4'd4);
  assign wr_isrb = bus.WE && (bus.ADDR == 4'd5);
  assign wr_imra = bus.WE && (bus.ADDR == 4'd6);
  assign wr_imrb = bus.WE && (bus.ADDR == 4'd7);
  assign wr_vr   = bus.WE && (bus.ADDR == 4'd8);

  assign eligible = ipr & imr;

  // Ascending scan so the highest-numbered eligible channel is the last hit.
  always_comb begin
    win     = 4'd0;
    win_vld = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (eligible[i]) begin
        win     = i[3:0];
        win_vld = 1'b1;
      end
    end
  end

  // An in-service bit at or above the winner blocks it (nesting rule).
  assign at_or_above = 16'hFFFF << win;
  assign win_onehot  = 16'h0001 << win;
  assign qualify     = win_vld && ((isr & at_or_above) == 16'h0000);
  assign ack         = bus.IACK && qualify;

  always_comb begin
    ier_n = ier;
    imr_n = imr;
    vr_n  = vr;
    if (wr_iera) ier_n[15:8] = bus.DAT_I;
    if (wr_ierb) ier_n[7:0]  = bus.DAT_I;
    if (wr_imra) imr_n[15:8] = bus.DAT_I;
    if (wr_imrb) imr_n[7:0]  = bus.DAT_I;
    if (wr_vr)   vr_n        = bus.DAT_I;

    // Clears first, then gate by the new enables, then new events on top so
    // a same-cycle pulse always survives a write-clear or acknowledge.
    ipr_n = ipr;
    if (wr_ipra) ipr_n[15:8] = ipr_n[15:8] & bus.DAT_I;
    if (wr_iprb) ipr_n[7:0]  = ipr_n[7:0]  & bus.DAT_I;
    if (ack)     ipr_n       = ipr_n & ~win_onehot;
    ipr_n = (ipr_n & ier_n) | (bus.SRC_PULSE & ier_n);

    // Write-clear, then acknowledge set (set wins), then auto-EOI VR write
    // wipes everything.
    isr_n = isr;
    if (wr_isra)        isr_n[15:8] = isr_n[15:8] & bus.DAT_I;
    if (wr_isrb)        isr_n[7:0]  = isr_n[7:0]  & bus.DAT_I;
    if (ack && vr[3])   isr_n       = isr_n | win_onehot;
    if (wr_vr && !bus.DAT_I[3]) isr_n = 16'h0000;
  end

  // Register stage: controller state and acknowledge outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      ier    <= 16'h0000;
      ipr    <= 16'h0000;
      isr    <= 16'h0000;
      imr    <= 16'h0000;
      vr     <= 8'h00;
      irq_p1 <= 1'b0;
      vec_p1 <= 8'h00;
      vld_p1 <= 1'b0;
    end else begin
      ier    <= ier_n;
      ipr    <= ipr_n;
      isr    <= isr_n;
      imr    <= imr_n;
      vr     <= vr_n;
      irq_p1 <= qualify;
      vld_p1 <= bus.IACK;
      if (bus.IACK) begin
        vec_p1 <= qualify ? {vr[7:4], win} : SPURIOUS_VEC;
      end
    end
  end

  assign bus.IRQ       = irq_p1;
  assign bus.VEC_O     = vec_p1;
  assign bus.VEC_VALID = vld_p1;

  always_comb begin
    bus.DAT_O = 8'h00;
    case (bus.ADDR)
      4'd0:    bus.DAT_O = ier[15:8];
      4'd1:    bus.DAT_O = ier[7:0];
      4'd2:    bus.DAT_O = ipr[15:8];
      4'd3:    bus.DAT_O = ipr[7:0];
      4'd4:    bus.DAT_O = isr[15:8];
      4'd5:    bus.DAT_O = isr[7:0];
      4'd6:    bus.DAT_O = imr[15:8];
      4'd7:    bus.DAT_O = imr[7:0];
      4'd8:    bus.DAT_O = vr;
      default: bus.DAT_O = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// Directed testbench for mfp_irq_ctrl.
module tb_mfp_irq_ctrl;
  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  mfp_irq_ctrl_if bus();

  mfp_irq_ctrl #(.SPURIOUS_VEC(8'h18)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  // Advance one clock; inputs change and outputs are sampled 1ns after posedge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    bus.ADDR = a;
    #1;
    d = bus.DAT_O;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.ADDR  = a;
    bus.DAT_I = d;
    bus.WE    = 1'b1;
    step();
    bus.WE    = 1'b0;
  endtask

  task automatic pulse(input logic [15:0] p);
    bus.SRC_PULSE = p;
    step();
    bus.SRC_PULSE = 16'h0000;
  endtask

  task automatic iack();
    bus.IACK = 1'b1;
    step();
    bus.IACK = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    checks++; if (bus.IRQ !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", bus.IRQ); end
    checks++; if (bus.VEC_VALID !== 1'b0) begin errors++; $display("FAIL rst_vld got %b exp 0", bus.VEC_VALID); end
    checks++; if (bus.VEC_O !== 8'h00) begin errors++; $display("FAIL rst_vec got %h exp 00", bus.VEC_O); end
    for (int a = 0; a < 10; a++) begin
      rd(a[3:0], d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_reg%0d got %h exp 00", a, d); end
    end
  endtask

  task automatic test_single_sw_eoi();
    logic [7:0] d;
    wr(4'd0, 8'h20);
    wr(4'd6, 8'h20);
    wr(4'd8, 8'h48);
    pulse(16'h2000);
    rd(4'd2, d);
    checks++; if (d !== 8'h20) begin errors++; $display("FAIL t1_ipra got %h exp 20", d); end
    checks++; if (bus.IRQ !== 1'b0) begin errors++; $display("FAIL t1_irq_lat1 got %b exp 0", bus.IRQ); end
    step();
    checks++; if (bus.IRQ !== 1'b1) begin errors++; $display("FAIL t1_irq_up got %b exp 1", bus.IRQ); end
    iack();
    checks++; if (bus.VEC_VALID !== 1'b1) begin errors++; $display("FAIL t1_vld got %b exp 1", bus.VEC_VALID); end
    checks++; if (bus.VEC_O !== 8'h4D) begin errors++; $display("FAIL t1_vec got %h exp 4d", bus.VEC_O); end
    rd(4'd2, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL t1_ipra_ack got %h exp 00", d); end
    rd(4'd4, d);
    checks++; if (d !== 8'h20) begin errors++; $display("FAIL t1_isra got %h exp 20", d); end
    step();
    checks++; if (bus.VEC_VALID !== 1'b0) begin errors++; $display("FAIL t1_vld_drop got %b exp 0", bus.VEC_VALID); end
    checks++; if (bus.IRQ !== 1'b0) begin errors++; $display("FAIL t1_irq_drop got %b exp 0", bus.IRQ); end
    wr(4'd4, 8'hDF);
    rd(4'd4, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL t1_isra_clr got %h exp 00", d); end
  endtask

  task automatic test_priority_nesting();
    logic [7:0] d;
    wr(4'd1, 8'h20);
    wr(4'd7, 8'h20);
    pulse(16'h2020);
    step();
    checks++; if (bus.IRQ !== 1'b1) begin errors++; $display("FAIL t2_irq got %b exp 1", bus.IRQ); end
    iack();
    checks++; if (bus.VEC_O !== 8'h4D) begin errors++; $display("FAIL t2_vec13 got %h exp 4d", bus.VEC_O); end
    step();
    checks++; if (bus.IRQ !== 1'b0) begin errors++; $display("FAIL t2_irq_nested got %b exp 0", bus.IRQ); end
    rd(4'd3, d);
    checks++; if (d !== 8'h20) begin errors++; $display("FAIL t2_iprb got %h exp 20", d); end
    // higher channel 14 preempts in-service 13
    wr(4'd0, 8'h60);
    wr(4'd6, 8'h60);
    pulse(16'h4000);
    step();
    checks++; if (bus.IRQ !== 1'b1) begin errors++; $display("FAIL t2_irq14 got %b exp 1", bus.IRQ); end
    iack();
    checks++; if (bus.VEC_O !== 8'h4E) begin errors++; $display("FAIL t2_vec14 got %h exp 4e", bus.VEC_O); end
    rd(4'd4, d);
    checks++; if (d !== 8'h60) begin errors++; $display("FAIL t2_isra got %h exp 60", d); end
    step();
    checks++; if (bus.IRQ !== 1'b0) begin errors++; $display("FAIL t2_irq_blk got %b exp 0", bus.IRQ); end
    wr(4'd4, 8'h00);
    step();
    checks++; if (bus.IRQ !== 1'b1) begin errors++; $display("FAIL t2_irq5 got %b exp 1", bus.IRQ); end
    iack();
    checks++; if (bus.VEC_O !== 8'h45) begin errors++; $display("FAIL t2_vec5 got %h exp 45", bus.VEC_O); end
    rd(4'd5, d);
    checks++; if (d !== 8'h20) begin errors++; $display("FAIL t2_isrb got %h exp 20", d); end
    wr(4'd5, 8'h00);
  endtask

  task automatic test_masking();
    logic [7:0] d;
    wr(4'd0, 8'h00);
    wr(4'd1, 8'h00);
    wr(4'd6, 8'h00);
    wr(4'd7, 8'h00);
    pulse(16'h0008);
    rd(4'd3, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL t3_ier0 got %h exp 00", d); end
    wr(4'd1, 8'h08);
    pulse(16'h0008);
    rd(4'd3, d);
    checks++; if (d !== 8'h08) begin errors++; $display("FAIL t3_masked_ipr got %h exp 08", d); end
    step();
    checks++; if (bus.IRQ !== 1'b0) begin errors++; $display("FAIL t3_masked_irq got %b exp 0", bus.IRQ); end
    wr(4'd7, 8'h08);
    step();
    checks++; if (bus.IRQ !== 1'b1) begin errors++; $display("FAIL t3_unmask_irq got %b exp 1", bus.IRQ); end
    wr(4'd1, 8'h00);
    rd(4'd3, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL t3_dis_ipr got %h exp 00", d); end
    step();
    checks++; if (bus.IRQ !== 1'b0) begin errors++; $display("FAIL t3_dis_irq got %b exp 0", bus.IRQ); end
  endtask

  task automatic test_auto_eoi_spurious();
    logic [7:0] d;
    wr(4'd8, 8'h40);
    wr(4'd1, 8'h04);
    wr(4'd7, 8'h04);
    pulse(16'h0004);
    step();
    iack();
    checks++; if (bus.VEC_O !== 8'h42) begin errors++; $display("FAIL t4_vec got %h exp 42", bus.VEC_O); end
    rd(4'd5, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL t4_isrb got %h exp 00", d); end
    rd(4'd3, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL t4_iprb got %h exp 00", d); end
    // back-to-back: second acknowledge finds nothing
    iack();
    checks++; if (bus.VEC_O !== 8'h18) begin errors++; $display("FAIL t4_spur_vec got %h exp 18", bus.VEC_O); end
    checks++; if (bus.VEC_VALID !== 1'b1) begin errors++; $display("FAIL t4_spur_vld got %b exp 1", bus.VEC_VALID); end
    rd(4'd1, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL t4_ierb got %h exp 04", d); end
    rd(4'd8, d);
    checks++; if (d !== 8'h40) begin errors++; $display("FAIL t4_vr got %h exp 40", d); end
    step();
    checks++; if (bus.VEC_VALID !== 1'b0) begin errors++; $display("FAIL t4_vld_drop got %b exp 0", bus.VEC_VALID); end
  endtask

  task automatic test_collisions();
    logic [7:0] d;
    wr(4'd8, 8'h48);
    wr(4'd1, 8'h80);
    wr(4'd7, 8'h80);
    // Case A: pulse vs IPRB write-clear
    bus.SRC_PULSE = 16'h0080;
    wr(4'd3, 8'h7F);
    bus.SRC_PULSE = 16'h0000;
    rd(4'd3, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL t5a_iprb got %h exp 80", d); end
    // Case B: pulse vs acknowledge of the same channel
    bus.SRC_PULSE = 16'h0080;
    iack();
    bus.SRC_PULSE = 16'h0000;
    checks++; if (bus.VEC_O !== 8'h47) begin errors++; $display("FAIL t5b_vec got %h exp 47", bus.VEC_O); end
    rd(4'd3, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL t5b_iprb got %h exp 80", d); end
    rd(4'd5, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL t5b_isrb got %h exp 80", d); end
    // ISR write-clear vs acknowledge set on channel 7: set wins
    wr(4'd5, 8'h00);
    bus.IACK = 1'b1;
    wr(4'd5, 8'h7F);
    bus.IACK = 1'b0;
    checks++; if (bus.VEC_O !== 8'h47) begin errors++; $display("FAIL t5c_vec got %h exp 47", bus.VEC_O); end
    rd(4'd5, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL t5c_isrb got %h exp 80", d); end
    // VR auto-EOI write with acknowledge: vector produced, ISR cleared
    pulse(16'h0080);
    wr(4'd5, 8'h00);
    bus.IACK = 1'b1;
    wr(4'd8, 8'h50);
    bus.IACK = 1'b0;
    checks++; if (bus.VEC_O !== 8'h47) begin errors++; $display("FAIL t5d_vec got %h exp 47", bus.VEC_O); end
    rd(4'd5, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL t5d_isrb got %h exp 00", d); end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] d;
    wr(4'd8, 8'h48);
    wr(4'd1, 8'h20);
    wr(4'd7, 8'h20);
    pulse(16'h0020);
    iack();
    wr(4'd0, 8'h80);
    wr(4'd6, 8'h80);
    pulse(16'h8000);
    step();
    checks++; if (bus.IRQ !== 1'b1) begin errors++; $display("FAIL t6_irq_pre got %b exp 1", bus.IRQ); end
    rd(4'd5, d);
    checks++; if (d !== 8'h20) begin errors++; $display("FAIL t6_isrb_pre got %h exp 20", d); end
    RST = 1'b1;
    bus.IACK = 1'b1;
    bus.SRC_PULSE = 16'h8020;
    step();
    RST = 1'b0;
    bus.IACK = 1'b0;
    bus.SRC_PULSE = 16'h0000;
    checks++; if (bus.IRQ !== 1'b0) begin errors++; $display("FAIL t6_irq got %b exp 0", bus.IRQ); end
    checks++; if (bus.VEC_VALID !== 1'b0) begin errors++; $display("FAIL t6_vld got %b exp 0", bus.VEC_VALID); end
    for (int a = 0; a < 9; a++) begin
      rd(a[3:0], d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL t6_reg%0d got %h exp 00", a, d); end
    end
    step();
    checks++; if (bus.IRQ !== 1'b0) begin errors++; $display("FAIL t6_irq_next got %b exp 0", bus.IRQ); end
    checks++; if (bus.VEC_VALID !== 1'b0) begin errors++; $display("FAIL t6_vld_next got %b exp 0", bus.VEC_VALID); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    RST           = 1'b1;
    bus.SRC_PULSE = 16'h0000;
    bus.ADDR      = 4'd0;
    bus.WE        = 1'b0;
    bus.DAT_I     = 8'h00;
    bus.IACK      = 1'b0;
    test_reset();
    test_single_sw_eoi();
    test_priority_nesting();
    test_masking();
    test_auto_eoi_spurious();
    test_collisions();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
